// File: rtl/nco_tune_ctrl_if.sv
// Request bundle for the two phase-increment requesters (CPU and CAT/hopper).
// Each requester presents valid/phi and receives a one-cycle ready pulse on accept.
interface nco_tune_ctrl_if #(
  parameter int APR = 22
) ();
  logic           req0_valid;
  logic [APR-1:0] req0_phi;
  logic           req0_ready;
  logic           req1_valid;
  logic [APR-1:0] req1_phi;
  logic           req1_ready;

  modport master (
    output req0_valid, req0_phi, req1_valid, req1_phi,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_phi, req1_valid, req1_phi,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/nco_tune_ctrl.sv
// Round-robin sequencer that applies phase-increment updates to one NCO, either in a single step
// or as a linear glide, and reports settled once the NCO pipeline has flushed the final value.
module nco_tune_ctrl #(
  parameter int             APR       = 22,
  parameter int             NCO_LAT   = 8,
  parameter logic [APR-1:0] RAMP_STEP = {APR{1'b0}},
  parameter logic [APR-1:0] PHI_RST   = {APR{1'b0}}
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clken,
  input  logic            nco_out_valid,
  nco_tune_ctrl_if.slave  req_if,
  output logic [APR-1:0]  phi_inc_o,
  output logic            busy,
  output logic            settled,
  output logic            grant_id
);

  localparam int CW = (NCO_LAT < 1) ? 1 : $clog2(NCO_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_RAMP  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [APR-1:0]  phi_q, phi_d;
  logic [APR-1:0]  target_q, target_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rdy0_q, rdy0_d;
  logic            rdy1_q, rdy1_d;
  logic            busy_q, busy_d;
  logic            settled_q, settled_d;
  logic            gid_q, gid_d;

  logic            any_req_s;
  logic            win_s;
  logic [APR-1:0]  sel_phi_s;
  logic signed [APR:0] diff_s;
  logic [APR:0]    mag_s;
  logic            last_step_s;

  // Distance to target is taken in APR+1 signed bits so a glide never wraps modulo 2^APR.
  assign any_req_s   = req_if.req0_valid | req_if.req1_valid;
  assign win_s       = (req_if.req0_valid && req_if.req1_valid) ? ~gid_q : req_if.req1_valid;
  assign sel_phi_s   = gid_q ? req_if.req1_phi : req_if.req0_phi;
  assign diff_s      = $signed({1'b0, target_q}) - $signed({1'b0, phi_q});
  assign mag_s       = diff_s[APR] ? $unsigned(-diff_s) : $unsigned(diff_s);
  assign last_step_s = (RAMP_STEP == {APR{1'b0}}) || (mag_s <= {1'b0, RAMP_STEP});

  // Next-state and registered-output logic for the IDLE/GRANT/RAMP/FLUSH sequencer.
  always_comb begin
    state_d   = state_q;
    phi_d     = phi_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    rdy0_d    = 1'b0;
    rdy1_d    = 1'b0;
    settled_d = settled_q;
    gid_d     = gid_q;

    case (state_q)
      S_IDLE: begin
        if (any_req_s) begin
          state_d = S_GRANT;
          gid_d   = win_s;
          rdy0_d  = ~win_s;
          rdy1_d  = win_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        target_d = sel_phi_s;
        if (sel_phi_s == phi_q) begin
          settled_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          settled_d = 1'b0;
          state_d   = S_RAMP;
        end
      end
      S_RAMP: begin
        if (!clken) begin
          state_d = S_RAMP;
        end else if (last_step_s) begin
          phi_d   = target_q;
          cnt_d   = CW'(NCO_LAT);
          state_d = S_FLUSH;
        end else if (diff_s[APR]) begin
          phi_d = phi_q - RAMP_STEP;
        end else begin
          phi_d = phi_q + RAMP_STEP;
        end
      end
      S_FLUSH: begin
        if (!clken) begin
          state_d = S_FLUSH;
        end else if (cnt_q != {CW{1'b0}}) begin
          cnt_d = cnt_q - CW'(1);
        end else if (nco_out_valid) begin
          settled_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          state_d = S_FLUSH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset drops any in-flight request immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      phi_q     <= PHI_RST;
      target_q  <= PHI_RST;
      cnt_q     <= {CW{1'b0}};
      rdy0_q    <= 1'b0;
      rdy1_q    <= 1'b0;
      busy_q    <= 1'b0;
      settled_q <= 1'b0;
      gid_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      phi_q     <= phi_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      rdy0_q    <= rdy0_d;
      rdy1_q    <= rdy1_d;
      busy_q    <= busy_d;
      settled_q <= settled_d;
      gid_q     <= gid_d;
    end
  end

  assign phi_inc_o         = phi_q;
  assign busy              = busy_q;
  assign settled           = settled_q;
  assign grant_id          = gid_q;
  assign req_if.req0_ready = rdy0_q;
  assign req_if.req1_ready = rdy1_q;

endmodule

// File: tb/tb_nco_tune_ctrl.sv
// Directed bench: dut0 applies updates in one step, dut1 glides with RAMP_STEP=0x1000.
module tb_nco_tune_ctrl;
  logic        clk;
  logic        reset_n;
  logic        clken;
  logic        out_valid;
  logic [21:0] phi0, phi1;
  logic        busy0, busy1, set0, set1, gid0, gid1;
  int          checks;
  int          failures;

  nco_tune_ctrl_if #(.APR(22)) if0 ();
  nco_tune_ctrl_if #(.APR(22)) if1 ();

  nco_tune_ctrl #(.APR(22), .NCO_LAT(8), .RAMP_STEP(22'h000000), .PHI_RST(22'h000000)) dut0 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .nco_out_valid(out_valid), .req_if(if0),
    .phi_inc_o(phi0), .busy(busy0), .settled(set0), .grant_id(gid0)
  );

  nco_tune_ctrl #(.APR(22), .NCO_LAT(8), .RAMP_STEP(22'h001000), .PHI_RST(22'h000000)) dut1 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .nco_out_valid(out_valid), .req_if(if1),
    .phi_inc_o(phi1), .busy(busy1), .settled(set1), .grant_id(gid1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    if0.req0_phi   = 22'h000100;
    if0.req0_valid = 1'b1;
    reset_n = 1'b0;
    repeat (3) tick();
    checks++; if (phi0 !== 22'h000000) begin failures++; $display("FAIL rst_phi got=%h exp=000000", phi0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy0); end
    checks++; if (set0 !== 1'b0) begin failures++; $display("FAIL rst_settled got=%b exp=0", set0); end
    checks++; if (if0.req0_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", if0.req0_ready); end
    checks++; if (gid0 !== 1'b0) begin failures++; $display("FAIL rst_gid got=%b exp=0", gid0); end
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k == 0) begin
        checks++; if (if0.req0_ready !== 1'b1) begin failures++; $display("FAIL rst_rel_ready got=%b exp=1", if0.req0_ready); end
        checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL rst_rel_busy got=%b exp=1", busy0); end
      end
      if (k == 1) begin
        checks++; if (if0.req0_ready !== 1'b0) begin failures++; $display("FAIL rst_rel_pulse got=%b exp=0", if0.req0_ready); end
      end
      if (k == 10) begin
        checks++; if (set0 !== 1'b0) begin failures++; $display("FAIL rst_rel_early got=%b exp=0", set0); end
      end
      if (k == 11) begin
        checks++; if (set0 !== 1'b1) begin failures++; $display("FAIL rst_rel_settled got=%b exp=1", set0); end
        checks++; if (phi0 !== 22'h000100) begin failures++; $display("FAIL rst_rel_phi got=%h exp=000100", phi0); end
      end
      if (if0.req0_ready) if0.req0_valid = 1'b0;
    end
  endtask

  task automatic test_single_step();
    if0.req0_phi   = 22'h0ABCDE;
    if0.req0_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k == 1) begin
        checks++; if (phi0 !== 22'h000100) begin failures++; $display("FAIL step_hold got=%h exp=000100", phi0); end
        checks++; if (set0 !== 1'b0) begin failures++; $display("FAIL step_unsettle got=%b exp=0", set0); end
      end
      if (k == 2) begin
        checks++; if (phi0 !== 22'h0ABCDE) begin failures++; $display("FAIL step_phi got=%h exp=0abcde", phi0); end
      end
      if (k == 10) begin
        checks++; if (set0 !== 1'b0 || busy0 !== 1'b1) begin failures++; $display("FAIL step_flush got=%b/%b exp=0/1", set0, busy0); end
      end
      if (k == 11) begin
        checks++; if (set0 !== 1'b1 || busy0 !== 1'b0) begin failures++; $display("FAIL step_settled got=%b/%b exp=1/0", set0, busy0); end
      end
      if (if0.req0_ready) if0.req0_valid = 1'b0;
    end
  endtask

  task automatic test_ramp();
    logic [21:0] exp_up [0:4];
    logic [21:0] exp_dn [0:4];
    exp_up = '{22'h000000, 22'h001000, 22'h002000, 22'h003000, 22'h003000};
    exp_dn = '{22'h003000, 22'h002000, 22'h001000, 22'h000800, 22'h000800};
    if1.req1_phi   = 22'h003000;
    if1.req1_valid = 1'b1;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (k >= 1 && k <= 5) begin
        checks++; if (phi1 !== exp_up[k-1]) begin failures++; $display("FAIL ramp_up_%0d got=%h exp=%h", k, phi1, exp_up[k-1]); end
      end
      if (k == 12) begin
        checks++; if (set1 !== 1'b0) begin failures++; $display("FAIL ramp_up_early got=%b exp=0", set1); end
      end
      if (k == 13) begin
        checks++; if (set1 !== 1'b1) begin failures++; $display("FAIL ramp_up_settled got=%b exp=1", set1); end
      end
      if (if1.req1_ready) if1.req1_valid = 1'b0;
    end
    if1.req0_phi   = 22'h000800;
    if1.req0_valid = 1'b1;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (k >= 1 && k <= 5) begin
        checks++; if (phi1 !== exp_dn[k-1]) begin failures++; $display("FAIL ramp_dn_%0d got=%h exp=%h", k, phi1, exp_dn[k-1]); end
      end
      if (k == 13) begin
        checks++; if (set1 !== 1'b1) begin failures++; $display("FAIL ramp_dn_settled got=%b exp=1", set1); end
      end
      if (if1.req0_ready) if1.req0_valid = 1'b0;
    end
  endtask

  task automatic test_round_robin();
    int n0, n1, at0, at1;
    logic g0, g1;
    n0 = 0; n1 = 0; at0 = -1; at1 = -1; g0 = 1'bx; g1 = 1'bx;
    if0.req0_phi   = 22'h000111;
    if0.req1_phi   = 22'h000222;
    if0.req0_valid = 1'b1;
    if0.req1_valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (if0.req0_ready) begin n0++; at0 = k; g0 = gid0; if0.req0_valid = 1'b0; end
      if (if0.req1_ready) begin n1++; at1 = k; g1 = gid0; if0.req1_valid = 1'b0; end
    end
    checks++; if (n0 != 1 || n1 != 1) begin failures++; $display("FAIL rr_pulses got=%0d/%0d exp=1/1", n0, n1); end
    checks++; if (at1 != 0) begin failures++; $display("FAIL rr_first got=%0d exp=0", at1); end
    checks++; if (at0 != 12) begin failures++; $display("FAIL rr_second got=%0d exp=12", at0); end
    checks++; if (g1 !== 1'b1 || g0 !== 1'b0) begin failures++; $display("FAIL rr_gid got=%b,%b exp=1,0", g1, g0); end
    checks++; if (phi0 !== 22'h000111 || set0 !== 1'b1) begin failures++; $display("FAIL rr_final got=%h/%b exp=000111/1", phi0, set0); end
  endtask

  task automatic test_clken_gate();
    out_valid      = 1'b0;
    if0.req0_phi   = 22'h012345;
    if0.req0_valid = 1'b1;
    for (int k = 0; k <= 42; k++) begin
      tick();
      if (k == 0) clken = 1'b1;
      else clken = ((k - 1) % 4 == 0);
      if (k == 41) out_valid = 1'b1;
      if (k == 1) begin
        checks++; if (phi0 !== 22'h000111) begin failures++; $display("FAIL gate_hold got=%h exp=000111", phi0); end
      end
      if (k == 2) begin
        checks++; if (phi0 !== 22'h012345) begin failures++; $display("FAIL gate_phi got=%h exp=012345", phi0); end
      end
      if (k == 37 || k == 41) begin
        checks++; if (set0 !== 1'b0 || busy0 !== 1'b1) begin failures++; $display("FAIL gate_wait_%0d got=%b/%b exp=0/1", k, set0, busy0); end
      end
      if (k == 42) begin
        checks++; if (set0 !== 1'b1 || busy0 !== 1'b0) begin failures++; $display("FAIL gate_settled got=%b/%b exp=1/0", set0, busy0); end
      end
      if (if0.req0_ready) if0.req0_valid = 1'b0;
    end
    clken     = 1'b1;
    out_valid = 1'b1;
  endtask

  task automatic test_reset_mid_ramp();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    if1.req1_phi   = 22'h003000;
    if1.req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (if1.req1_ready) if1.req1_valid = 1'b0;
    end
    checks++; if (phi1 !== 22'h002000) begin failures++; $display("FAIL mid_pre got=%h exp=002000", phi1); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (phi1 !== 22'h000000 || busy1 !== 1'b0 || set1 !== 1'b0) begin failures++; $display("FAIL mid_reset got=%h/%b/%b exp=000000/0/0", phi1, busy1, set1); end
    checks++; if (phi0 !== 22'h000000) begin failures++; $display("FAIL mid_reset_dut0 got=%h exp=000000", phi0); end
    tick();
    reset_n        = 1'b1;
    if1.req1_valid = 1'b1;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (k == 4) begin
        checks++; if (phi1 !== 22'h003000) begin failures++; $display("FAIL mid_redo_phi got=%h exp=003000", phi1); end
      end
      if (k == 13) begin
        checks++; if (set1 !== 1'b1) begin failures++; $display("FAIL mid_redo_settled got=%b exp=1", set1); end
      end
      if (if1.req1_ready) if1.req1_valid = 1'b0;
    end
    if1.req0_phi   = 22'h003000;
    if1.req0_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (k == 0) begin
        checks++; if (if1.req0_ready !== 1'b1 || busy1 !== 1'b1 || set1 !== 1'b1) begin failures++; $display("FAIL eq_grant got=%b/%b/%b exp=1/1/1", if1.req0_ready, busy1, set1); end
      end
      if (k == 1) begin
        checks++; if (busy1 !== 1'b0 || set1 !== 1'b1 || phi1 !== 22'h003000) begin failures++; $display("FAIL eq_done got=%b/%b/%h exp=0/1/003000", busy1, set1, phi1); end
      end
      if (if1.req0_ready) if1.req0_valid = 1'b0;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    clken = 1'b1;
    out_valid = 1'b1;
    if0.req0_valid = 1'b0; if0.req1_valid = 1'b0; if0.req0_phi = 22'h0; if0.req1_phi = 22'h0;
    if1.req0_valid = 1'b0; if1.req1_valid = 1'b0; if1.req0_phi = 22'h0; if1.req1_phi = 22'h0;
    test_reset();
    test_single_step();
    test_ramp();
    test_round_robin();
    test_clken_gate();
    test_reset_mid_ramp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
